// File: rtl/udp_pkg.sv
// Shared UDP path definitions: drain FSM encoding plus the header constants
// used by the filter stage.
package udp_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } drain_state_t;

  localparam int          IPV4_ADDR_WIDTH = 32;
  localparam logic [15:0] ETHERTYPE_IPV4  = 16'h0800;
  localparam logic [3:0]  IPV4_VERSION    = 4'd4;
  localparam logic [7:0]  IP_PROTO_UDP    = 8'd17;

endpackage

// File: rtl/axis_out_reg.sv
// Single-entry AXIS output register; accepts a new word whenever it is empty
// or its current word is being taken downstream in the same cycle.
module axis_out_reg #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk_i,
  input  logic                  a_rst_n_i,
  input  logic                  clr,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  out_valid,
  input  logic                  out_ready
);

  assign in_ready = ~out_valid | out_ready;

  always_ff @(posedge clk_i or negedge a_rst_n_i) begin
    if (!a_rst_n_i) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (clr) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (in_valid && in_ready) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
      out_last  <= in_last;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/udp_frame_drain.sv
// Cut-through drain of accepted frames from the filter's FWFT FIFO onto an
// AXI4-Stream master, with tlast derived from the tapped write-side beat count.
module udp_frame_drain
  import udp_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int CNT_WIDTH  = 12
) (
  input  logic                    clk_i,
  input  logic                    a_rst_n_i,
  input  logic                    frame_valid_i,
  input  logic                    wr_beat_i,
  input  logic                    wr_last_i,
  input  logic                    fifo_rst_n_i,
  input  logic [DATA_WIDTH-1:0]   fifo_data_i,
  input  logic                    fifo_empty_i,
  output logic                    fifo_rd_en_o,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata_o,
  output logic [DATA_WIDTH/8-1:0] m_axis_tkeep_o,
  output logic                    m_axis_tlast_o,
  output logic                    m_axis_tvalid_o,
  input  logic                    m_axis_tready_i,
  output logic [31:0]             frame_cnt_o,
  output logic                    abort_o
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  drain_state_t state, state_nxt;

  logic [CNT_WIDTH-1:0] wr_cnt, rd_cnt, total;
  logic [CNT_WIDTH-1:0] wr_cnt_nxt, rd_cnt_nxt, total_nxt;
  logic [CNT_WIDTH-1:0] wr_base, total_base, total_eff;
  logic                 total_known, total_known_nxt, known_base, known_eff;
  logic                 wr_fin, sat, pop, pop_last, out_rdy, hs_last, enter_idle;
  logic                 out_vld, out_last;
  logic [DATA_WIDTH-1:0] out_data;

  assign hs_last    = out_vld & out_last & m_axis_tready_i;
  assign enter_idle = (state == DONE) & hs_last;

  // Counters restart on the DONE handshake, but a write landing in that same
  // cycle already belongs to the next frame and is counted on top of zero.
  assign wr_base    = enter_idle ? '0 : wr_cnt;
  assign total_base = enter_idle ? '0 : total;
  assign known_base = ~enter_idle & total_known;

  assign sat       = (wr_base == CNT_MAX);
  assign wr_fin    = wr_beat_i & wr_last_i & ~known_base;
  assign known_eff = known_base | wr_fin;
  assign total_eff = !wr_fin ? total_base : (sat ? CNT_MAX : wr_base + CNT_ONE);

  assign pop = (state == STREAM) & ~fifo_empty_i & out_rdy
             & ~(total_known & (rd_cnt == total));

  // Overlong frame: once the write count pins at max with no last seen,
  // the next popped beat closes the frame.
  assign pop_last = (sat & ~known_eff) | (known_eff & ((rd_cnt + CNT_ONE) == total_eff));

  always_comb begin
    state_nxt       = state;
    wr_cnt_nxt      = wr_base;
    total_nxt       = total_base;
    total_known_nxt = known_base;
    rd_cnt_nxt      = enter_idle ? '0 : rd_cnt;
    if (wr_beat_i && !known_base && !sat) wr_cnt_nxt = wr_base + CNT_ONE;
    if (wr_fin) begin
      total_nxt       = total_eff;
      total_known_nxt = 1'b1;
    end
    if (pop) rd_cnt_nxt = rd_cnt + CNT_ONE;
    unique case (state)
      IDLE:    if (frame_valid_i)   state_nxt = STREAM;
      STREAM:  if (pop && pop_last) state_nxt = DONE;
      DONE:    if (hs_last)         state_nxt = IDLE;
      default:                      state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge a_rst_n_i) begin
    if (!a_rst_n_i) begin
      state       <= IDLE;
      wr_cnt      <= '0;
      rd_cnt      <= '0;
      total       <= '0;
      total_known <= 1'b0;
      frame_cnt_o <= '0;
      abort_o     <= 1'b0;
    end else begin
      abort_o <= ~fifo_rst_n_i & (state != IDLE);
      if (hs_last && fifo_rst_n_i) frame_cnt_o <= frame_cnt_o + 32'd1;
      if (!fifo_rst_n_i) begin
        state       <= IDLE;
        wr_cnt      <= '0;
        rd_cnt      <= '0;
        total       <= '0;
        total_known <= 1'b0;
      end else begin
        state       <= state_nxt;
        wr_cnt      <= wr_cnt_nxt;
        rd_cnt      <= rd_cnt_nxt;
        total       <= total_nxt;
        total_known <= total_known_nxt;
      end
    end
  end

  axis_out_reg #(.DATA_WIDTH(DATA_WIDTH)) u_out (
    .clk_i     (clk_i),
    .a_rst_n_i (a_rst_n_i),
    .clr       (~fifo_rst_n_i),
    .in_valid  (pop),
    .in_data   (fifo_data_i),
    .in_last   (pop_last),
    .in_ready  (out_rdy),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_valid (out_vld),
    .out_ready (m_axis_tready_i)
  );

  assign fifo_rd_en_o    = pop;
  assign m_axis_tdata_o  = out_data;
  assign m_axis_tlast_o  = out_last;
  assign m_axis_tvalid_o = out_vld;
  assign m_axis_tkeep_o  = {(DATA_WIDTH/8){out_vld}};

endmodule
